// File: rtl/breakout_pkg.sv
// Shared Breakout definitions.
// Holds the screen, paddle and ball geometry used by the ball controller,
// the renderer and the brick logic. It also holds the game state type and
// the per-axis direction encoding.
package breakout_pkg;

  localparam int GEO_SCREEN_W  = 640;
  localparam int GEO_SCREEN_H  = 480;
  localparam int GEO_BALL_SIZE = 8;
  localparam int GEO_PADDLE_W  = 64;
  localparam int GEO_PADDLE_Y  = 440;
  localparam int GEO_STEP      = 2;
  localparam int GEO_LIVES     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  // One bit per axis; a set bit means the axis moves towards zero.
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level that is already synchronous to clk.
// Ports: clk, rst (sync, active-high), in (level), pulse (one clk per 0->1).
// The history register resets to 1. A level that is already high when
// reset is released therefore does not count as an edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic in_q;

  always_ff @(posedge clk) begin
    if (rst) in_q <= 1'b1;
    else     in_q <= in;
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/ball_controller.sv
// Breakout ball motion and life tracking.
// The ball advances once per rising edge of the divider's tick. It bounces
// off the walls and the paddle, deflects on brick hits, and loses a life
// on a miss.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   tick           divided-clock level; each rising edge is one update
//   serve          launch from IDLE, restart from OVER
//   paddle_x       paddle left edge
//   brick_hit      one-cycle brick collision pulse
//   ball_x/ball_y  ball top-left corner (registered)
//   lives          remaining lives
//   missed         one-cycle pulse when the ball is lost
//   game_over      high while in OVER
module ball_controller
  import breakout_pkg::*;
#(
  parameter int SCREEN_W  = GEO_SCREEN_W,
  parameter int SCREEN_H  = GEO_SCREEN_H,
  parameter int BALL_SIZE = GEO_BALL_SIZE,
  parameter int PADDLE_W  = GEO_PADDLE_W,
  parameter int PADDLE_Y  = GEO_PADDLE_Y,
  parameter int STEP      = GEO_STEP,
  parameter int LIVES     = GEO_LIVES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       serve,
  input  logic [9:0] paddle_x,
  input  logic       brick_hit,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [1:0] lives,
  output logic       missed,
  output logic       game_over
);

  // All geometry comparisons are done on 11 bits so that sums never wrap.
  localparam logic [10:0] STEP11   = 11'(STEP);
  localparam logic [10:0] BS11     = 11'(BALL_SIZE);
  localparam logic [10:0] PW11     = 11'(PADDLE_W);
  localparam logic [10:0] PY11     = 11'(PADDLE_Y);
  localparam logic [10:0] XMAX11   = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] YMISS11  = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0]  PARK_OFF = 10'((PADDLE_W - BALL_SIZE) / 2);
  localparam logic [9:0]  PARK_Y   = 10'(PADDLE_Y - BALL_SIZE);
  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

  state_t state;
  logic   dx_neg, dy_neg, brick_pend;
  logic   upd_p0;

  // ---- stage 0: update strobe from the tick level ----
  rise_detect u_rise (
    .clk   (clk),
    .rst   (rst),
    .in    (tick),
    .pulse (upd_p0)
  );

  // ---- next-position evaluation from the current registers ----
  logic [10:0] x11, y11, px11;
  logic        dy_eff;
  logic        paddle_hit;
  logic [9:0]  x_nxt, y_nxt;
  logic        dx_nxt, dy_nxt, miss_nxt;

  assign x11  = {1'b0, ball_x};
  assign y11  = {1'b0, ball_y};
  assign px11 = {1'b0, paddle_x};

  // A pending brick hit flips vertical direction before the move is
  // evaluated, so the reflection takes effect in this same update.
  assign dy_eff = dy_neg ^ brick_pend;

  assign paddle_hit = (y11 + BS11 <= PY11) &&
                      (y11 + BS11 + STEP11 >= PY11) &&
                      (x11 + BS11 > px11) &&
                      (x11 < px11 + PW11);

  always_comb begin
    x_nxt    = ball_x;
    dx_nxt   = dx_neg;
    y_nxt    = ball_y;
    dy_nxt   = dy_eff;
    miss_nxt = 1'b0;

    if (dx_neg == DIR_NEG) begin
      if (x11 < STEP11) begin
        x_nxt  = '0;
        dx_nxt = DIR_POS;
      end else begin
        x_nxt = 10'(x11 - STEP11);
      end
    end else begin
      if (x11 + STEP11 >= XMAX11) begin
        x_nxt  = 10'(XMAX11);
        dx_nxt = DIR_NEG;
      end else begin
        x_nxt = 10'(x11 + STEP11);
      end
    end

    if (dy_eff == DIR_NEG) begin
      if (y11 < STEP11) begin
        y_nxt  = '0;
        dy_nxt = DIR_POS;
      end else begin
        y_nxt = 10'(y11 - STEP11);
      end
    end else if (paddle_hit) begin
      y_nxt  = PARK_Y;
      dy_nxt = DIR_NEG;
    end else if (y11 + STEP11 >= YMISS11) begin
      miss_nxt = 1'b1;
    end else begin
      y_nxt = 10'(y11 + STEP11);
    end
  end

  // ---- stage 1: registered state and outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lives      <= LIVES_INIT;
      missed     <= 1'b0;
      dx_neg     <= DIR_POS;
      dy_neg     <= DIR_NEG;
      brick_pend <= 1'b0;
      ball_x     <= PARK_OFF;
      ball_y     <= PARK_Y;
    end else begin
      missed <= 1'b0;
      case (state)
        IDLE: begin
          ball_x     <= paddle_x + PARK_OFF;
          ball_y     <= PARK_Y;
          brick_pend <= 1'b0;
          if (serve) begin
            state  <= PLAY;
            dx_neg <= DIR_POS;
            dy_neg <= DIR_NEG;
          end
        end
        PLAY: begin
          if (upd_p0) begin
            // A hit arriving with this update is kept for the next one.
            brick_pend <= brick_hit;
            ball_x     <= x_nxt;
            dx_neg     <= dx_nxt;
            dy_neg     <= dy_nxt;
            if (miss_nxt) begin
              missed     <= 1'b1;
              lives      <= lives - 2'd1;
              brick_pend <= 1'b0;
              state      <= (lives == 2'd1) ? OVER : IDLE;
            end else begin
              ball_y <= y_nxt;
            end
          end else if (brick_hit) begin
            brick_pend <= 1'b1;
          end
        end
        OVER: begin
          if (serve) begin
            state <= IDLE;
            lives <= LIVES_INIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign game_over = (state == OVER);

endmodule

// File: tb/tb_ball_controller.sv
module tb_ball_controller;

  localparam int W = 640, H = 480, B = 8, PW = 64, PY = 440, ST = 2, NL = 3;
  localparam int M_IDLE = 0, M_PLAY = 1, M_OVER = 2;

  logic       clk = 1'b0;
  logic       rst, tick, serve, brick_hit;
  logic [9:0] paddle_x;
  logic [9:0] ball_x, ball_y;
  logic [1:0] lives;
  logic       missed, game_over;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integer game state, velocities as +1/-1.
  int m_state, mx, my, mvx, mvy, mlives, mpend, mtq, mmiss;
  int track, off, half, hcnt;

  ball_controller dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .serve     (serve),
    .paddle_x  (paddle_x),
    .brick_hit (brick_hit),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .lives     (lives),
    .missed    (missed),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int upd, ox, oy;
    mmiss = 0;
    if (rst) begin
      m_state = M_IDLE; mx = (PW - B) / 2; my = PY - B;
      mvx = 1; mvy = -1; mpend = 0; mlives = NL; mtq = 1;
      return;
    end
    upd = (tick && !mtq) ? 1 : 0;
    mtq = tick;
    if (m_state == M_IDLE) begin
      mx = (int'(paddle_x) + (PW - B) / 2) % 1024;
      my = PY - B;
      mpend = 0;
      if (serve) begin m_state = M_PLAY; mvx = 1; mvy = -1; end
    end else if (m_state == M_PLAY) begin
      if (upd) begin
        if (mpend) mvy = -mvy;
        mpend = brick_hit;
        ox = mx; oy = my;
        if (mvx < 0) begin
          if (ox < ST) begin mx = 0; mvx = 1; end else mx = ox - ST;
        end else begin
          if (ox + ST >= W - B) begin mx = W - B; mvx = -1; end else mx = ox + ST;
        end
        if (mvy < 0) begin
          if (oy < ST) begin my = 0; mvy = 1; end else my = oy - ST;
        end else if (oy + B <= PY && oy + B + ST >= PY &&
                     ox + B > int'(paddle_x) && ox < int'(paddle_x) + PW) begin
          my = PY - B; mvy = -1;
        end else if (oy + ST >= H - B) begin
          mmiss = 1; mpend = 0; mlives--;
          m_state = (mlives == 0) ? M_OVER : M_IDLE;
        end else begin
          my = oy + ST;
        end
      end else if (brick_hit) begin
        mpend = 1;
      end
    end else begin
      if (serve) begin m_state = M_IDLE; mlives = NL; end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("ball_x", ball_x, mx);
    chk("ball_y", ball_y, my);
    chk("lives", lives, mlives);
    chk("missed", missed, mmiss);
    chk("game_over", game_over, (m_state == M_OVER) ? 1 : 0);
  endtask

  // One full tick period: low for two cycles, then high for two cycles.
  task automatic tick_edge();
    tick = 1'b0; cycle(); cycle();
    tick = 1'b1; cycle(); cycle();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1; serve = 1'b0; brick_hit = 1'b0; paddle_x = 10'd100;
    mtq = 1; m_state = M_IDLE;
    repeat (3) cycle();
    chk("rst_x", ball_x, 28);
    chk("rst_y", ball_y, 432);
    chk("rst_lives", lives, 3);
    rst = 1'b0;
    cycle();
    chk("park_x", ball_x, 128);
    chk("park_y", ball_y, 432);
    repeat (3) tick_edge();
    chk("idle_still_x", ball_x, 128);
    chk("idle_still_y", ball_y, 432);

    // Serve, then three updates.
    serve = 1'b1; cycle(); serve = 1'b0;
    repeat (3) tick_edge();
    chk("move_x", ball_x, 134);
    chk("move_y", ball_y, 426);

    // Brick hit while rising turns the ball down at the next update only.
    tick = 1'b0; brick_hit = 1'b1; cycle(); brick_hit = 1'b0; cycle();
    tick = 1'b1; cycle(); cycle();
    chk("brick_y", ball_y, 428);
    tick_edge();
    chk("brick_once_y", ball_y, 430);
    // Falling onto the paddle at 100..163.
    tick_edge();
    chk("paddle_y", ball_y, 432);
    tick_edge();
    chk("bounce_y", ball_y, 430);

    // Paddle out of reach: lose every life.
    paddle_x = 10'd900;
    hcnt = 0;
    for (int i = 0; i < 30000 && m_state != M_OVER; i++) begin
      serve = (m_state == M_IDLE) ? 1'b1 : 1'b0;
      hcnt++;
      if (hcnt == 2) begin tick = ~tick; hcnt = 0; end
      cycle();
    end
    serve = 1'b0;
    chk("over_flag", game_over, 1);
    chk("over_lives", lives, 0);
    repeat (3) tick_edge();
    serve = 1'b1; cycle(); serve = 1'b0;
    chk("restart_lives", lives, 3);
    chk("restart_over", game_over, 0);

    // Randomized play against the model.
    track = 1; off = 20; half = 2; hcnt = 0;
    for (int i = 0; i < 40000; i++) begin
      rst = ($urandom_range(0, 5999) == 0);
      serve = (m_state != M_PLAY) && ($urandom_range(0, 7) == 0);
      brick_hit = ($urandom_range(0, 39) == 0);
      if (serve) begin
        track = ($urandom_range(0, 3) != 0);
        off = int'($urandom_range(0, 80)) - 10;
      end
      if (m_state == M_PLAY && track) begin
        if (mx - off < 0) paddle_x = 10'd0;
        else paddle_x = 10'(mx - off);
      end else if (m_state != M_PLAY && $urandom_range(0, 15) == 0) begin
        paddle_x = 10'($urandom_range(0, 1023));
      end
      hcnt++;
      if (hcnt >= half) begin
        tick = ~tick; hcnt = 0; half = $urandom_range(1, 3);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_controller.md
# ball_controller

Ball motion and life-tracking stage of the Breakout game, directly downstream of the clock divider.

- Consumes the divider's slow square wave `tick` in the system `clk` domain and advances the ball once per rising edge of `tick`.
- Handles wall and paddle bounces, brick-hit deflection, misses, serve and game-over.
- Drives ball coordinates to the VGA renderer and collision logic.

## Interface

Parameters:
- `SCREEN_W`, 640: playfield width in pixels.
- `SCREEN_H`, 480: playfield height in pixels.
- `BALL_SIZE`, 8: ball side length in pixels.
- `PADDLE_W`, 64: paddle width in pixels.
- `PADDLE_Y`, 440: paddle top row.
- `STEP`, 2: pixels moved per axis per update.
- `LIVES`, 3: lives at start or restart (≤3).

Ports:
- `clk` in 1: system clock. One clock only.
- `rst` in 1: reset, synchronous, active-high.
- `tick` in 1: divided-clock level from the divider, synchronous to `clk`. Each rising edge is one update.
- `serve` in 1: launch ball (IDLE) or restart game (OVER).
- `paddle_x` in 10: paddle left edge.
- `brick_hit` in 1: one-cycle pulse from brick collision logic.
- `ball_x` out 10, `ball_y` out 10: ball top-left corner.
- `lives` out 2: remaining lives.
- `missed` out 1: one-cycle pulse on a lost ball.
- `game_over` out 1: high while in OVER.

## Operation

- **Update strobe:** `upd = tick & ~tick_q`, where `tick_q` is registered `tick`. `tick_q` resets to 1, so a `tick` already high at reset release produces no update.
- **States:** IDLE, PLAY, OVER.
- **IDLE:**
  - Every `clk`, ball parks on the paddle: `ball_x = paddle_x + (PADDLE_W-BALL_SIZE)/2`, `ball_y = PADDLE_Y - BALL_SIZE`.
  - `serve` → PLAY with dx=+1, dy=−1 (up).
- **PLAY, on `upd`:**
  - Pending brick flag set → invert dy first, then clear the flag.
  - Horizontal:
    - dx<0 and `ball_x < STEP` → `ball_x` = 0, dx=+1.
    - dx>0 and `ball_x + STEP ≥ SCREEN_W-BALL_SIZE` → clamp to `SCREEN_W-BALL_SIZE`, dx=−1.
    - Otherwise move by `STEP`.
  - Vertical up: `ball_y < STEP` → `ball_y` = 0, dy=+1. Otherwise move by `STEP`.
  - Vertical down, paddle hit when all three hold:
    - `ball_y + BALL_SIZE ≤ PADDLE_Y`
    - `ball_y + BALL_SIZE + STEP ≥ PADDLE_Y`
    - `ball_x + BALL_SIZE > paddle_x` and `ball_x < paddle_x + PADDLE_W`
    - Result: `ball_y = PADDLE_Y - BALL_SIZE`, dy=−1.
  - Vertical down, else if `ball_y + STEP ≥ SCREEN_H - BALL_SIZE`: miss.
    - `missed` = 1 for one cycle and `lives` decrements.
    - Next state is OVER if `lives` was 1, otherwise IDLE.
  - Vertical down, otherwise move by `STEP`.
  - Both axes are evaluated in the same update, so corners reflect both directions.
- **`brick_hit`:** latched into a sticky pending flag. Accepted only in PLAY; ignored in IDLE/OVER. Multiple pulses before one update give a single inversion.
- **OVER:**
  - Ball frozen, `game_over` = 1.
  - `serve` → IDLE, `lives = LIVES`, `game_over` cleared.
- **Arithmetic:** all comparisons use 11-bit zero-extended operands, so no wrap occurs.

## Timing

- Reset values:
  - state IDLE, `lives = LIVES`, `missed` 0, `game_over` 0.
  - dx=+1, dy=−1, brick flag 0.
  - `ball_x = (PADDLE_W-BALL_SIZE)/2` (28), `ball_y = PADDLE_Y-BALL_SIZE` (432).
- Outputs are registered. The position changes on the `clk` edge where `tick` is first sampled high (1-cycle latency from the rising edge of `tick`).
- IDLE park tracks `paddle_x` with 1-cycle latency.
- `serve` and `upd` in the same IDLE cycle → transition only; first move at the next `upd`.
- `brick_hit` in the same cycle as `upd` → applied at the next `upd`, not this one.
- `rst` overrides everything, including mid-PLAY and in the same cycle as `missed`.

## Structure

- Shared package `breakout_pkg`:
  - screen/paddle/ball geometry constants, shared with the renderer and brick logic.
  - `state_t` enum {IDLE, PLAY, OVER}.
  - direction encoding (1 bit per axis, 1 = negative).
- Sub-module `rise_detect` (clk, rst, in → pulse) produces `upd`; reusable for button inputs.

## Test plan

- **Reset and park:** `rst`, `paddle_x=100` → `ball_x=128`, `ball_y=432`, `lives=3`; no motion while `tick` toggles.
- **Serve and move:** `serve`, then 3 `tick` edges → `ball_x` +6, `ball_y` 426.
- **Left wall:** start at `ball_x=1`, dx<0, one `upd` → `ball_x=0`, dx positive; next `upd` → `ball_x=2`.
- **Paddle hit:** `ball_y=431` falling, `ball_x` overlapping paddle, `upd` → `ball_y=432`, dy up.
- **Miss:** paddle absent with `ball_y=471` falling, `upd` → `missed` pulse, `lives` 3→2, IDLE.
- **Game over and brick:**
  - Three misses → `game_over=1`, `lives=0`; `serve` → `lives=3`, IDLE.
  - `brick_hit` while rising → dy down at next `upd` only.
